// File: rtl/mc6803_sci.sv
// MC6803 serial communications interface: RMCR/TRCSR/RDR/TDR at 0x10-0x13.
// NRZ frames of 1 start, 8 data (LSB first) and 1 stop bit; bit period chosen by RMCR.SS.
module mc6803_sci #(
  parameter int unsigned RATE0 = 16,
  parameter int unsigned RATE1 = 128,
  parameter int unsigned RATE2 = 1024,
  parameter int unsigned RATE3 = 4096
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       cs,
  input  logic       vma,
  input  logic       rw,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       rxd,
  output logic       txd,
  output logic       irq_sci
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

  // Terminal count (period - 1) for each SS setting.
  function automatic logic [15:0] f_plim(input logic [1:0] ss);
    logic [15:0] v;
    case (ss)
      2'd0:    v = 16'(RATE0 - 32'd1);
      2'd1:    v = 16'(RATE1 - 32'd1);
      2'd2:    v = 16'(RATE2 - 32'd1);
      default: v = 16'(RATE3 - 32'd1);
    endcase
    return v;
  endfunction

  logic [3:0]  r_rmcr;
  logic [4:0]  r_ctl;
  logic [7:0]  r_tdr, r_rdr;
  logic        r_rdrf, r_orfe, r_tdre, r_rx_clr, r_tx_clr, r_irq;

  logic        w_acc, w_wr, w_rd;
  logic        w_wr_rmcr, w_wr_trcsr, w_wr_tdr, w_rd_trcsr, w_rd_rdr;
  logic        w_re, w_te, w_rx_clear, w_tx_clear;

  tx_state_t   r_tx_state, w_tx_next;
  logic        w_tx_load, w_tx_tick;
  logic [15:0] r_tx_cnt, r_tx_plim;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_sh;
  logic        r_txd;

  rx_state_t   r_rx_state, w_rx_next;
  logic        r_rx_s1, r_rx_s2, w_rxs;
  logic        w_rx_tick, w_rx_half, w_rx_ok, w_rx_fe;
  logic [15:0] r_rx_cnt, r_rx_plim;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh;

  assign w_acc      = cs & vma;
  assign w_wr       = w_acc & ~rw;
  assign w_rd       = w_acc & rw;
  assign w_wr_rmcr  = w_wr & (addr == 2'd0);
  assign w_wr_trcsr = w_wr & (addr == 2'd1);
  assign w_wr_tdr   = w_wr & (addr == 2'd3);
  assign w_rd_trcsr = w_rd & (addr == 2'd1);
  assign w_rd_rdr   = w_rd & (addr == 2'd2);
  assign w_re       = r_ctl[3];
  assign w_te       = r_ctl[1];
  assign w_rx_clear = w_rd_rdr & r_rx_clr;
  assign w_tx_clear = w_wr_tdr & r_tx_clr;
  assign w_tx_tick  = (r_tx_cnt == r_tx_plim);
  assign w_rx_tick  = (r_rx_cnt == r_rx_plim);
  assign w_rx_half  = (r_rx_cnt == {1'b0, r_rx_plim[15:1]});
  assign w_rxs      = r_rx_s2;
  assign txd        = r_txd;
  assign irq_sci    = r_irq;

  always_comb begin
    data_out = 8'h00;
    case (addr)
      2'd0:    data_out = {4'h0, r_rmcr};
      2'd1:    data_out = {r_rdrf, r_orfe, r_tdre, r_ctl};
      2'd2:    data_out = r_rdr;
      default: data_out = r_tdr;
    endcase
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_rmcr <= 4'h0;
      r_ctl  <= 5'h00;
      r_tdr  <= 8'h00;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_rmcr)  r_rmcr <= data_in[3:0];
      if (w_wr_trcsr) r_ctl  <= data_in[4:0];
      if (w_wr_tdr)   r_tdr  <= data_in;
      r_irq <= (r_ctl[4] & (r_rdrf | r_orfe)) | (r_ctl[2] & r_tdre);
    end
  end

  // TDRE and its clear-arm: a load event always beats a pending clear.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_tdre   <= 1'b1;
      r_tx_clr <= 1'b0;
    end else begin
      if (w_tx_load)       r_tdre <= 1'b1;
      else if (w_tx_clear) r_tdre <= 1'b0;
      if (w_tx_clear)                 r_tx_clr <= 1'b0;
      else if (w_rd_trcsr && r_tdre)  r_tx_clr <= 1'b1;
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_load = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_te && !r_tdre) begin
          w_tx_next = TX_START;
          w_tx_load = 1'b1;
        end else begin
          w_tx_next = TX_IDLE;
        end
      end
      TX_START: begin
        if (w_tx_tick) w_tx_next = TX_DATA;
        else           w_tx_next = TX_START;
      end
      TX_DATA: begin
        if (w_tx_tick && (r_tx_bit == 3'd7)) w_tx_next = TX_STOP;
        else                                 w_tx_next = TX_DATA;
      end
      TX_STOP: begin
        if (w_tx_tick && w_te && !r_tdre) begin
          w_tx_next = TX_START;
          w_tx_load = 1'b1;
        end else if (w_tx_tick) begin
          w_tx_next = TX_IDLE;
        end else begin
          w_tx_next = TX_STOP;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= 16'h0000;
      r_tx_plim  <= 16'h0000;
      r_tx_bit   <= 3'd0;
      r_tx_sh    <= 8'h00;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_tx_load) begin
        r_tx_sh   <= r_tdr;
        r_tx_plim <= f_plim(r_rmcr[1:0]);
        r_tx_cnt  <= 16'h0000;
        r_tx_bit  <= 3'd0;
        r_txd     <= 1'b0;
      end else if (r_tx_state == TX_IDLE) begin
        r_tx_cnt <= 16'h0000;
        r_txd    <= 1'b1;
      end else if (!w_tx_tick) begin
        r_tx_cnt <= r_tx_cnt + 16'd1;
      end else begin
        r_tx_cnt <= 16'h0000;
        if (r_tx_state == TX_STOP || (r_tx_state == TX_DATA && r_tx_bit == 3'd7)) begin
          r_txd <= 1'b1;
        end else begin
          r_txd   <= r_tx_sh[0];
          r_tx_sh <= {1'b0, r_tx_sh[7:1]};
          if (r_tx_state == TX_DATA) r_tx_bit <= r_tx_bit + 3'd1;
        end
      end
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_ok   = 1'b0;
    w_rx_fe   = 1'b0;
    if (!w_re) begin
      w_rx_next = RX_IDLE;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rxs) w_rx_next = RX_START;
          else        w_rx_next = RX_IDLE;
        end
        RX_START: begin
          if (w_rx_half && w_rxs) w_rx_next = RX_IDLE;
          else if (w_rx_half)     w_rx_next = RX_DATA;
          else                    w_rx_next = RX_START;
        end
        RX_DATA: begin
          if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP;
          else                                 w_rx_next = RX_DATA;
        end
        RX_STOP: begin
          if (w_rx_tick && w_rxs) begin
            w_rx_next = RX_IDLE;
            w_rx_ok   = 1'b1;
          end else if (w_rx_tick) begin
            w_rx_next = RX_WAITHI;
            w_rx_fe   = 1'b1;
          end else begin
            w_rx_next = RX_STOP;
          end
        end
        RX_WAITHI: begin
          if (w_rxs) w_rx_next = RX_IDLE;
          else       w_rx_next = RX_WAITHI;
        end
        default: w_rx_next = RX_IDLE;
      endcase
    end
  end

  // Synchronizer, receive sequencing and the sampling counter.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= 16'h0000;
      r_rx_plim  <= 16'h0000;
      r_rx_bit   <= 3'd0;
      r_rx_sh    <= 8'h00;
    end else begin
      r_rx_s1    <= rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_state <= w_rx_next;
      if (!w_re || r_rx_state == RX_IDLE || r_rx_state == RX_WAITHI) begin
        r_rx_cnt <= 16'h0000;
        r_rx_bit <= 3'd0;
        if (w_re && r_rx_state == RX_IDLE && !w_rxs) r_rx_plim <= f_plim(r_rmcr[1:0]);
      end else if (r_rx_state == RX_START) begin
        if (w_rx_half) r_rx_cnt <= 16'h0000;
        else           r_rx_cnt <= r_rx_cnt + 16'd1;
      end else if (w_rx_tick) begin
        r_rx_cnt <= 16'h0000;
        if (r_rx_state == RX_DATA) begin
          r_rx_sh  <= {w_rxs, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 3'd1;
        end
      end else begin
        r_rx_cnt <= r_rx_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_rdr    <= 8'h00;
      r_rdrf   <= 1'b0;
      r_orfe   <= 1'b0;
      r_rx_clr <= 1'b0;
    end else begin
      if (w_rx_fe) begin
        r_rdr  <= r_rx_sh;
        r_orfe <= 1'b1;
      end else if (w_rx_ok && r_rdrf) begin
        r_orfe <= 1'b1;
      end else if (w_rx_ok) begin
        r_rdr  <= r_rx_sh;
        r_rdrf <= 1'b1;
      end else if (w_rx_clear) begin
        r_rdrf <= 1'b0;
        r_orfe <= 1'b0;
      end
      if (w_rx_clear)                              r_rx_clr <= 1'b0;
      else if (w_rd_trcsr && (r_rdrf || r_orfe))   r_rx_clr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc6803_sci.sv
// Self-checking bench for mc6803_sci: register vector table, directed serial sequences,
// and randomized traffic checked against a flag-level model of the SCI rules.
`timescale 1ns/1ps
module tb_mc6803_sci;

  logic       clk = 1'b0;
  logic       rst_n, cs, vma, rw, rxd;
  logic [1:0] addr;
  logic [7:0] data_in, data_out;
  logic       txd, irq_sci;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] v, v2;

  typedef struct {
    logic       wr;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    logic       irq;
  } vec_t;
  vec_t vecs[15];

  logic       m_rdrf, m_orfe, m_tdre, m_rx_arm, m_tx_arm;
  logic [7:0] m_rdr;
  logic [4:0] m_ctl;
  int         m_p;
  int         rates[4] = '{16, 128, 1024, 4096};

  mc6803_sci dut (
    .clk(clk), .RST_n(rst_n), .cs(cs), .vma(vma), .rw(rw), .addr(addr),
    .data_in(data_in), .data_out(data_out), .rxd(rxd), .txd(txd), .irq_sci(irq_sci)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cs = 1'b0; vma = 1'b0; rw = 1'b1; addr = 2'd0; data_in = 8'h00; rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk); cs = 1'b1; vma = 1'b1; rw = 1'b0; addr = a; data_in = d;
    @(negedge clk); cs = 1'b0; vma = 1'b0; rw = 1'b1;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk); cs = 1'b1; vma = 1'b1; rw = 1'b1; addr = a;
    #1 d = data_out;
    @(negedge clk); cs = 1'b0; vma = 1'b0;
  endtask

  // Look at a register without an access (cs low), so no side effects.
  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    addr = a; rw = 1'b1;
    #1 d = data_out;
  endtask

  // Called just after the load edge; checks all 10*p samples of the frame.
  task automatic tx_expect(input logic [7:0] d, input int p, input string name);
    logic [9:0] frame;
    frame = {1'b1, d, 1'b0};
    for (int i = 0; i < 10 * p; i++) begin
      chk($sformatf("%s bit%0d", name, i / p), {31'd0, txd}, {31'd0, frame[i / p]});
      @(negedge clk);
    end
    chk({name, " idle"}, {31'd0, txd}, 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input int p);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      @(negedge clk); rxd = f[b];
      repeat (p - 1) @(negedge clk);
    end
    @(negedge clk); rxd = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [7:0] m_trcsr();
    return {m_rdrf, m_orfe, m_tdre, m_ctl};
  endfunction

  function automatic logic m_irq();
    return (m_ctl[4] & (m_rdrf | m_orfe)) | (m_ctl[2] & m_tdre);
  endfunction

  task automatic m_read_trcsr();
    logic [7:0] r;
    cpu_read(2'd1, r);
    chk("rnd trcsr read", {24'd0, r}, {24'd0, m_trcsr()});
    if (m_rdrf || m_orfe) m_rx_arm = 1'b1;
    if (m_tdre) m_tx_arm = 1'b1;
  endtask

  task automatic m_read_rdr();
    logic [7:0] r;
    cpu_read(2'd2, r);
    chk("rnd rdr read", {24'd0, r}, {24'd0, m_rdr});
    if (m_rx_arm) begin m_rdrf = 1'b0; m_orfe = 1'b0; m_rx_arm = 1'b0; end
  endtask

  task automatic m_rx(input logic [7:0] d, input logic stop);
    if (!stop) begin m_rdr = d; m_orfe = 1'b1; end
    else if (m_rdrf) m_orfe = 1'b1;
    else begin m_rdr = d; m_rdrf = 1'b1; end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 2'd1, 8'h00, 8'h20, 1'b0};
    vecs[2]  = '{1'b0, 2'd2, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 2'd3, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 2'd0, 8'hFF, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 8'h00, 8'h0F, 1'b0};
    vecs[6]  = '{1'b1, 2'd0, 8'h05, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 8'h00, 8'h05, 1'b0};
    vecs[8]  = '{1'b1, 2'd1, 8'h04, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 2'd1, 8'h00, 8'h24, 1'b1};
    vecs[10] = '{1'b1, 2'd3, 8'h5A, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 2'd1, 8'h00, 8'h04, 1'b0};
    vecs[12] = '{1'b0, 2'd3, 8'h00, 8'h5A, 1'b0};
    vecs[13] = '{1'b1, 2'd1, 8'h1C, 8'h00, 1'b0};
    vecs[14] = '{1'b0, 2'd1, 8'h00, 8'h1C, 1'b0};

    // Reset state, observed without bus accesses.
    do_reset();
    peek(2'd0, v); chk("reset rmcr", {24'd0, v}, 32'h00);
    peek(2'd1, v); chk("reset trcsr", {24'd0, v}, 32'h20);
    peek(2'd2, v); chk("reset rdr", {24'd0, v}, 32'h00);
    peek(2'd3, v); chk("reset tdr", {24'd0, v}, 32'h00);
    chk("reset txd", {31'd0, txd}, 32'd1);
    chk("reset irq", {31'd0, irq_sci}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) begin
        cpu_write(vecs[i].a, vecs[i].d);
      end else begin
        cpu_read(vecs[i].a, v);
        chk($sformatf("vec%0d read", i), {24'd0, v}, {24'd0, vecs[i].exp});
      end
      @(negedge clk);
      chk($sformatf("vec%0d irq", i), {31'd0, irq_sci}, {31'd0, vecs[i].irq});
    end

    // Transmit 0xA5 at 16 clk/bit; TDRE low for exactly one clock.
    do_reset();
    cpu_write(2'd0, 8'h00);
    cpu_write(2'd1, 8'h02);
    cpu_read(2'd1, v); chk("t1 trcsr", {24'd0, v}, 32'h22);
    cpu_write(2'd3, 8'hA5);
    peek(2'd1, v); chk("t1 tdre low", {24'd0, v}, 32'h02);
    chk("t1 txd before", {31'd0, txd}, 32'd1);
    @(negedge clk);
    peek(2'd1, v); chk("t1 tdre back", {24'd0, v}, 32'h22);
    tx_expect(8'hA5, 16, "t1 tx");
    peek(2'd1, v); chk("t1 trcsr after", {24'd0, v}, 32'h22);

    // Receive 0x3C, then the TRCSR/RDR clear sequence.
    do_reset();
    cpu_read(2'd1, v);
    cpu_write(2'd3, 8'h00);
    cpu_write(2'd1, 8'h18);
    send_rx(8'h3C, 1'b1, 16);
    peek(2'd1, v); chk("t2 trcsr", {24'd0, v}, 32'h98);
    chk("t2 irq set", {31'd0, irq_sci}, 32'd1);
    cpu_read(2'd1, v); chk("t2 trcsr read", {24'd0, v}, 32'h98);
    cpu_read(2'd2, v); chk("t2 rdr", {24'd0, v}, 32'h3C);
    peek(2'd1, v); chk("t2 cleared", {24'd0, v}, 32'h18);
    @(negedge clk);
    chk("t2 irq clear", {31'd0, irq_sci}, 32'd0);

    // Overrun.
    send_rx(8'h11, 1'b1, 16);
    send_rx(8'h22, 1'b1, 16);
    peek(2'd1, v); chk("t3 trcsr", {24'd0, v}, 32'hD8);
    peek(2'd2, v); chk("t3 rdr kept", {24'd0, v}, 32'h11);
    cpu_read(2'd1, v);
    cpu_read(2'd2, v); chk("t3 rdr read", {24'd0, v}, 32'h11);
    peek(2'd1, v); chk("t3 cleared", {24'd0, v}, 32'h18);

    // Framing error, then a short glitch, then a good frame.
    send_rx(8'h55, 1'b0, 16);
    peek(2'd1, v); chk("t4 fe trcsr", {24'd0, v}, 32'h58);
    peek(2'd2, v); chk("t4 fe rdr", {24'd0, v}, 32'h55);
    cpu_read(2'd1, v);
    cpu_read(2'd2, v);
    peek(2'd1, v); chk("t4 fe cleared", {24'd0, v}, 32'h18);
    @(negedge clk); rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    peek(2'd1, v); chk("t4 glitch", {24'd0, v}, 32'h18);
    send_rx(8'h96, 1'b1, 16);
    peek(2'd1, v); chk("t4 after glitch", {24'd0, v}, 32'h98);
    peek(2'd2, v); chk("t4 after glitch rdr", {24'd0, v}, 32'h96);

    // TIE interrupt and the TDRE clear sequence.
    do_reset();
    cpu_write(2'd1, 8'h06);
    @(negedge clk);
    chk("t5 irq tdre", {31'd0, irq_sci}, 32'd1);
    cpu_write(2'd3, 8'h33);
    @(negedge clk);
    peek(2'd1, v); chk("t5 no arm", {24'd0, v}, 32'h26);
    chk("t5 txd idle", {31'd0, txd}, 32'd1);
    cpu_read(2'd1, v); chk("t5 trcsr", {24'd0, v}, 32'h26);
    cpu_write(2'd3, 8'h81);
    chk("t5 irq still", {31'd0, irq_sci}, 32'd1);
    peek(2'd1, v); chk("t5 tdre clr", {24'd0, v}, 32'h06);
    @(negedge clk);
    chk("t5 irq drop", {31'd0, irq_sci}, 32'd0);
    peek(2'd1, v); chk("t5 tdre set", {24'd0, v}, 32'h26);
    tx_expect(8'h81, 16, "t5 tx");
    chk("t5 irq back", {31'd0, irq_sci}, 32'd1);

    // SS=01 frame; rate change, queued byte and TE clear happen mid-frame.
    do_reset();
    cpu_write(2'd0, 8'h01);
    cpu_write(2'd1, 8'h02);
    cpu_read(2'd1, v);
    cpu_write(2'd3, 8'hC3);
    @(negedge clk);
    fork
      tx_expect(8'hC3, 128, "t6 tx");
      begin
        repeat (100) @(negedge clk);
        cpu_write(2'd0, 8'h00);
        cpu_read(2'd1, v2);
        chk("t6 mid trcsr", {24'd0, v2}, 32'h22);
        cpu_write(2'd3, 8'h77);
        cpu_write(2'd1, 8'h00);
      end
    join
    repeat (300) @(negedge clk);
    chk("t6 stays idle", {31'd0, txd}, 32'd1);
    peek(2'd1, v); chk("t6 trcsr", {24'd0, v}, 32'h00);

    // Asynchronous reset mid-frame.
    do_reset();
    cpu_write(2'd1, 8'h02);
    cpu_read(2'd1, v);
    cpu_write(2'd3, 8'h00);
    repeat (50) @(negedge clk);
    chk("t6 mid low", {31'd0, txd}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("t6 rst txd", {31'd0, txd}, 32'd1);
    peek(2'd1, v); chk("t6 rst trcsr", {24'd0, v}, 32'h20);
    chk("t6 rst irq", {31'd0, irq_sci}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic against the model.
    do_reset();
    m_rdrf = 1'b0; m_orfe = 1'b0; m_tdre = 1'b1; m_rx_arm = 1'b0; m_tx_arm = 1'b0;
    m_rdr = 8'h00; m_ctl = 5'h1A; m_p = rates[0];
    cpu_write(2'd1, 8'h1A);
    for (int it = 0; it < 30; it++) begin
      int op;
      logic [7:0] d;
      logic stop;
      logic [1:0] ss;
      op = int'($urandom_range(0, 5));
      d = 8'($urandom);
      case (op)
        0, 1: begin
          if ($urandom_range(0, 3) == 0) begin
            ss = 2'($urandom_range(0, 1));
            cpu_write(2'd0, {6'd0, ss});
            m_p = rates[ss];
          end
          stop = ($urandom_range(0, 7) != 0);
          send_rx(d, stop, m_p);
          m_rx(d, stop);
        end
        2: begin m_read_trcsr(); m_read_rdr(); end
        3: m_read_rdr();
        4: m_read_trcsr();
        default: begin
          m_read_trcsr();
          cpu_write(2'd3, d);
          if (m_tx_arm) begin m_tdre = 1'b0; m_tx_arm = 1'b0; end
          if (!m_tdre) begin
            @(negedge clk);
            m_tdre = 1'b1;
            tx_expect(d, m_p, "rnd tx");
          end
        end
      endcase
      @(negedge clk);
      peek(2'd1, v); chk($sformatf("rnd%0d trcsr", it), {24'd0, v}, {24'd0, m_trcsr()});
      peek(2'd2, v); chk($sformatf("rnd%0d rdr", it), {24'd0, v}, {24'd0, m_rdr});
      chk($sformatf("rnd%0d irq", it), {31'd0, irq_sci}, {31'd0, m_irq()});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
